// File: rtl/mesi_mbus_if.sv
// Request, main-bus and completion signals shared by the MESI main-bus master
// and whatever sits on the other side of it.
interface mesi_mbus_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int NUM_SNOOP      = 3,
  parameter int CNT_WIDTH      = 3
);
  logic                      req_valid;
  logic                      req_ready;
  logic [MBUS_CMD_WIDTH-1:0] req_cmd;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd;
  logic [ADDR_WIDTH-1:0]     mbus_addr;
  logic                      mbus_ack;
  logic [NUM_SNOOP-1:0]      cbus_ack;
  logic                      done_valid;
  logic                      done_timeout;
  logic                      busy;
  logic [CNT_WIDTH-1:0]      fifo_count;

  modport master (
    input  req_valid, req_cmd, req_addr,
    input  mbus_ack, cbus_ack,
    output req_ready, mbus_cmd, mbus_addr,
    output done_valid, done_timeout, busy, fifo_count
  );

  modport slave (
    output req_valid, req_cmd, req_addr,
    output mbus_ack, cbus_ack,
    input  req_ready, mbus_cmd, mbus_addr,
    input  done_valid, done_timeout, busy, fifo_count
  );
endinterface

// File: rtl/mesi_mbus_master.sv
// Queued main-bus master: issues RD/WR and broadcast variants, collects
// snoop acknowledges, waits for the bus ack and aborts on timeout.
module mesi_mbus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int NUM_SNOOP      = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 255
) (
  input logic         clk,
  input logic         rst,
  mesi_mbus_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [MBUS_CMD_WIDTH-1:0] C_NOP = '0;
  localparam logic [MBUS_CMD_WIDTH-1:0] C_MAX = MBUS_CMD_WIDTH'(4);
  localparam logic [MBUS_CMD_WIDTH-1:0] C_WRB = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] C_RDB = MBUS_CMD_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SNOOP,
    S_WAIT_ACK,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [MBUS_CMD_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      done_q;
  logic                      to_q;
  logic [NUM_SNOOP-1:0]      sticky_q;
  logic [TW-1:0]             wait_q;

  logic [MBUS_CMD_WIDTH-1:0] mem_cmd [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     mem_addr [FIFO_DEPTH];
  logic [PW-1:0]             wptr_q;
  logic [PW-1:0]             rptr_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  logic                      ready_q;

  logic                 cmd_ok;
  logic                 push;
  logic                 pop;
  logic                 ack_c;
  logic [NUM_SNOOP-1:0] cbus_c;
  logic                 snoop_all;
  logic [TW-1:0]        wait_inc;
  logic                 wait_to;
  logic                 is_broad;

  // Unknown acknowledges count as not-acknowledged.
  assign ack_c = (bus.mbus_ack === 1'b1);

  for (genvar i = 0; i < NUM_SNOOP; i++) begin : g_cb
    assign cbus_c[i] = (bus.cbus_ack[i] === 1'b1);
  end

  assign cmd_ok = (bus.req_cmd != C_NOP) &&
                  (bus.req_cmd <= C_MAX);
  assign push   = bus.req_valid && ready_q && cmd_ok;
  assign pop    = (state_q == S_IDLE) &&
                  (count_q != '0);

  assign snoop_all = &(sticky_q | cbus_c);
  assign wait_inc  = wait_q + TW'(1);
  assign wait_to   = wait_inc >= TW'(TIMEOUT);
  assign is_broad  = (cmd_q == C_WRB) ||
                     (cmd_q == C_RDB);

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + CW'(1);
      pop && !push: count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      ready_q <= count_d < CW'(FIFO_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wptr_q]  <= bus.req_cmd;
      mem_addr[wptr_q] <= bus.req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      sticky_q <= '0;
      wait_q   <= '0;
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q  <= S_ISSUE;
            cmd_q    <= mem_cmd[rptr_q];
            addr_q   <= mem_addr[rptr_q];
            sticky_q <= '0;
            wait_q   <= '0;
          end
        end
        S_ISSUE: begin
          state_q <= is_broad ? S_WAIT_SNOOP : S_WAIT_ACK;
        end
        S_WAIT_SNOOP: begin
          wait_q   <= wait_inc;
          sticky_q <= sticky_q | cbus_c;
          if (wait_to) begin
            state_q <= S_DONE;
            cmd_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b1;
            to_q    <= 1'b1;
          end else if (snoop_all) begin
            state_q <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          wait_q <= wait_inc;
          // A late ack still beats the timeout in the same cycle.
          if (ack_c || wait_to) begin
            state_q <= S_DONE;
            cmd_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b1;
            to_q    <= !ack_c;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.mbus_cmd     = cmd_q;
  assign bus.mbus_addr    = addr_q;
  assign bus.done_valid   = done_q;
  assign bus.done_timeout = to_q;
  assign bus.fifo_count   = count_q;
  assign bus.busy         = (state_q != S_IDLE) ||
                            (count_q != '0);

endmodule
